// File: rtl/prog_multimodulus_divider.sv
// prog_multimodulus_divider
//   Programmable integer divider with ratio law R = 2^n + P (n-stage 2/3
//   chain equivalent). A new ratio is offered through a valid/ready handshake
//   into a single shadow register and becomes active only at a period
//   boundary, so every output period is whole.
// Ports:
//   in_clk    - clock, rising edge
//   rst       - asynchronous active-low reset
//   en        - count enable; low freezes pos, outputs and active ratio
//   cfg_valid - ratio offer
//   cfg_ready - shadow register empty
//   cfg_p     - programming word P (bits [n-1:0] used)
//   cfg_n     - requested stage count n (clamped to MIN_STAGES..N_STAGES)
//   out_clk   - divided clock, high for floor(R/2) cycles per period
//   mout_clk  - one-cycle pulse on the last cycle of each period
//   cur_ratio - ratio currently in force
//   cfg_err   - one-cycle flag: accepted cfg_n was clamped
module prog_multimodulus_divider #(
  parameter  int N_STAGES   = 8,
  parameter  int MIN_STAGES = 2,
  localparam int NW         = $clog2(N_STAGES + 1)
) (
  input  logic                in_clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [N_STAGES-1:0] cfg_p,
  input  logic [NW-1:0]       cfg_n,
  output logic                out_clk,
  output logic                mout_clk,
  output logic [N_STAGES:0]   cur_ratio,
  output logic                cfg_err
);

  localparam int RW = N_STAGES + 1;
  localparam logic [NW-1:0] MIN_N       = NW'(MIN_STAGES);
  localparam logic [NW-1:0] MAX_N       = NW'(N_STAGES);
  localparam logic [RW-1:0] ONE_R       = {{N_STAGES{1'b0}}, 1'b1};
  localparam logic [RW-1:0] RESET_RATIO = {1'b1, {N_STAGES{1'b0}}};

  // R = 2^n + (P & (2^n - 1)); n is already clamped by the caller.
  function automatic logic [RW-1:0] ratio_of(input logic [NW-1:0]       n_eff,
                                             input logic [N_STAGES-1:0] p);
    logic [RW-1:0] top;
    logic [RW-1:0] mask;
    top  = ONE_R << n_eff;
    mask = top - ONE_R;
    return top + ({1'b0, p} & mask);
  endfunction

  logic [RW-1:0] pos_r;
  logic [RW-1:0] ratio_r;
  logic [RW-1:0] shadow_r;
  logic          ready_r;     // high = shadow empty
  logic          out_clk_r;
  logic          mout_r;
  logic          cfg_err_r;

  logic          n_low_s;
  logic          n_high_s;
  logic [NW-1:0] n_eff_s;
  logic [RW-1:0] new_ratio_s;
  logic [RW-1:0] half_s;
  logic [RW-1:0] last_s;
  logic          accept_s;
  logic          boundary_s;

  // Clamp the requested stage count and derive the offered ratio.
  always_comb begin
    n_low_s  = (cfg_n < MIN_N);
    n_high_s = (cfg_n > MAX_N);
    if (n_low_s) begin
      n_eff_s = MIN_N;
    end else if (n_high_s) begin
      n_eff_s = MAX_N;
    end else begin
      n_eff_s = cfg_n;
    end
    new_ratio_s = ratio_of(n_eff_s, cfg_p);
  end

  // Period decode against the active ratio.
  always_comb begin
    half_s     = {1'b0, ratio_r[RW-1:1]};
    last_s     = ratio_r - ONE_R;
    accept_s   = cfg_valid & ready_r;
    boundary_s = en & (pos_r == last_s);
  end

  // Position counter, registered outputs and the double-buffered ratio.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      pos_r     <= {RW{1'b0}};
      ratio_r   <= RESET_RATIO;
      shadow_r  <= RESET_RATIO;
      ready_r   <= 1'b1;
      out_clk_r <= 1'b0;
      mout_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      if (en) begin
        out_clk_r <= (pos_r < half_s);
        mout_r    <= (pos_r == last_s);
        pos_r     <= boundary_s ? {RW{1'b0}} : (pos_r + ONE_R);
      end
      // Consume needs a full shadow, accept needs an empty one, so the two
      // never collide; an offer landing on a boundary waits a full period.
      if (boundary_s && !ready_r) begin
        ratio_r <= shadow_r;
        ready_r <= 1'b1;
      end else if (accept_s) begin
        shadow_r <= new_ratio_s;
        ready_r  <= 1'b0;
      end
      cfg_err_r <= accept_s & (n_low_s | n_high_s);
    end
  end

  assign out_clk   = out_clk_r;
  assign mout_clk  = mout_r;
  assign cur_ratio = ratio_r;
  assign cfg_ready = ready_r;
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_prog_multimodulus_divider.sv
// Directed bench for prog_multimodulus_divider (N_STAGES = 8). The driver
// pushes one expected record per output period (length in clocks, high
// clocks, ratio in force after the closing pulse); the monitor measures each
// period and pops/compares on every mout_clk pulse.
module tb_prog_multimodulus_divider;

  logic       in_clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_p;
  logic [3:0] cfg_n;
  logic       out_clk;
  logic       mout_clk;
  logic [8:0] cur_ratio;
  logic       cfg_err;

  typedef struct {
    int len;
    int high;
    int nxt;
  } per_t;

  per_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  prog_multimodulus_divider #(.N_STAGES(8), .MIN_STAGES(2)) dut (
    .in_clk   (in_clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_p    (cfg_p),
    .cfg_n    (cfg_n),
    .out_clk  (out_clk),
    .mout_clk (mout_clk),
    .cur_ratio(cur_ratio),
    .cfg_err  (cfg_err)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic push(input int len, input int high, input int nxt);
    per_t e;
    e.len  = len;
    e.high = high;
    e.nxt  = nxt;
    exp_q.push_back(e);
  endtask

  task automatic wait_mout();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      tick(1);
      if (mout_clk) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mout_timeout: got no pulse, expected one within 1200 cycles");
    end
  endtask

  // One-cycle offer while ready is high; checks the handshake result.
  task automatic offer(input int n, input int p, input int err_exp);
    cfg_n     = 4'(n);
    cfg_p     = 8'(p);
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    chk("ready_after_accept", int'(cfg_ready), 0);
    chk("cfg_err", int'(cfg_err), err_exp);
  endtask

  // Monitor: count clocks since the last pulse; compare on each pulse.
  initial begin : monitor
    int   cnt;
    int   hcnt;
    logic r;
    per_t e;
    cnt  = 0;
    hcnt = 0;
    forever begin
      @(posedge in_clk);
      r = rst;
      #3;
      if (!r) begin
        cnt  = 0;
        hcnt = 0;
      end else begin
        cnt++;
        if (out_clk) hcnt++;
        if (mout_clk) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL period_unexpected: got period of %0d, expected none", cnt);
          end else begin
            e = exp_q.pop_front();
            chk("period_len", cnt, e.len);
            chk("period_high", hcnt, e.high);
            chk("next_ratio", int'(cur_ratio), e.nxt);
          end
          cnt  = 0;
          hcnt = 0;
        end
      end
    end
  end

  initial begin : driver
    rst       = 1'b0;
    en        = 1'b1;
    cfg_valid = 1'b0;
    cfg_p     = 8'd0;
    cfg_n     = 4'd0;
    tick(3);
    chk("rst_out_clk", int'(out_clk), 0);
    chk("rst_mout_clk", int'(mout_clk), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    chk("rst_ratio", int'(cur_ratio), 256);
    chk("rst_err", int'(cfg_err), 0);
    rst = 1'b1;
    tick(1);
    chk("first_out_clk", int'(out_clk), 1);
    chk("first_mout_clk", int'(mout_clk), 0);

    // n=2, p=3 mid-period: 256 period completes, then R=7.
    tick(8);
    offer(2, 3, 0);
    push(256, 128, 7);
    wait_mout();
    chk("ratio_7", int'(cur_ratio), 7);
    chk("ready_after_consume", int'(cfg_ready), 1);
    push(7, 3, 7);
    wait_mout();

    // Extremes and clamping, each offered at pos 0.
    offer(2, 0, 0);
    push(7, 3, 4);
    wait_mout();
    chk("ratio_4", int'(cur_ratio), 4);
    offer(8, 255, 0);
    push(4, 2, 511);
    wait_mout();
    chk("ratio_511", int'(cur_ratio), 511);
    offer(0, 255, 1);
    push(511, 255, 7);
    wait_mout();
    chk("ratio_clamp_low", int'(cur_ratio), 7);
    offer(12, 5, 1);
    push(7, 3, 261);
    wait_mout();
    chk("ratio_clamp_high", int'(cur_ratio), 261);

    // Back-to-back: R=9 accepted, R=18 held stalled until the boundary.
    offer(3, 1, 0);
    cfg_n     = 4'd4;
    cfg_p     = 8'd2;
    cfg_valid = 1'b1;
    tick(3);
    chk("ready_stalled", int'(cfg_ready), 0);
    chk("ratio_still_261", int'(cur_ratio), 261);
    push(261, 130, 9);
    wait_mout();
    chk("ready_reopen", int'(cfg_ready), 1);
    chk("ratio_9", int'(cur_ratio), 9);
    tick(1);
    cfg_valid = 1'b0;
    chk("second_accepted", int'(cfg_ready), 0);
    push(9, 4, 18);
    wait_mout();
    chk("ratio_18", int'(cur_ratio), 18);

    // Offer accepted exactly on the boundary edge applies one period later.
    push(18, 9, 18);
    tick(17);
    cfg_n     = 4'd2;
    cfg_p     = 8'd1;
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    chk("bnd_mout", int'(mout_clk), 1);
    chk("bnd_ratio_kept", int'(cur_ratio), 18);
    chk("bnd_ready", int'(cfg_ready), 0);
    push(18, 9, 5);
    wait_mout();
    chk("ratio_5", int'(cur_ratio), 5);

    // en low for 5 cycles in the low half: period stretches to 10.
    push(10, 2, 5);
    tick(3);
    en = 1'b0;
    tick(5);
    chk("frozen_out_clk", int'(out_clk), 0);
    chk("frozen_mout_clk", int'(mout_clk), 0);
    en = 1'b1;
    wait_mout();
    chk("ratio_after_en", int'(cur_ratio), 5);

    // Reset mid-period with a pending shadow (R=8) that must be lost.
    offer(3, 0, 0);
    tick(3);
    rst = 1'b0;
    #1;
    chk("midrst_out_clk", int'(out_clk), 0);
    chk("midrst_mout_clk", int'(mout_clk), 0);
    chk("midrst_ready", int'(cfg_ready), 1);
    chk("midrst_ratio", int'(cur_ratio), 256);
    exp_q.delete();
    tick(2);
    rst = 1'b1;
    push(256, 128, 256);
    wait_mout();
    chk("shadow_lost", int'(cur_ratio), 256);

    tick(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
